cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
Multi-cycle control sequencer for the 16-bit core.
- Fetches each instruction over an imem req/ack handshake and latches the 4-bit opcode (ins[15:12]).
- Steps through DECODE/EXEC/MEM/WB and drives the datapath selects: ALU source, immediate use, writeback mux, PC control and register write enable.
- Owns memory wait-state handling and bus-timeout fault detection.

Parameters:
- TIMEOUT, 15, maximum wait cycles for an unacknowledged imem/dmem request before fault (1..255).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ins  in  16  instruction word from imem, valid when imem_ack=1.
- imem_ack  in  1  instruction fetch acknowledge.
- dmem_ack  in  1  data access acknowledge.
- alu_zero  in  1  ALU zero flag, sampled in EXEC.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write enable (store).
- ir_load  out  1  instruction-register load strobe.
- pc_en  out  1  PC update strobe.
- pc_src_br  out  1  PC mux: 1 = branch target, 0 = PC+1.
- alu_src_imm  out  1  ALU B operand: 1 = immediate, 0 = register.
- alu_op  out  2  00 add, 01 sub (branch compare), 10 funct-decoded (R-type).
- reg_we  out  1  register-file write strobe.
- wb_sel_mem  out  1  writeback mux: 1 = dmem data, 0 = ALU result.
- halted  out  1  core stopped by HALT.
- fault  out  1  sticky fault flag.
- fault_code  out  2  01 illegal opcode, 10 imem timeout, 11 dmem timeout.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, opcode register=0, wait counter=0.
  - All outputs 0, except imem_req, which follows the FETCH decode once rst_n deasserts.
- Opcodes:
  - 0000 LOAD, 0001 ALUI, 0010 BEQ, 0011 RTYPE, 1000 STORE, 1111 HALT.
  - All other opcodes are illegal.
- Output timing:
  - Outputs are Moore decodes of {state, opcode_q}.
  - ir_load and pc_en in FETCH are Mealy: asserted in the same cycle imem_ack=1.
- FETCH:
  - imem_req=1 until ack.
  - On imem_ack: ir_load=1, pc_en=1, pc_src_br=0, opcode_q<=ins[15:12], next state DECODE.
- DECODE (1 cycle):
  - Illegal opcode: FAULT, fault_code=01.
  - HALT: HALTED.
  - Otherwise: EXEC.
- EXEC (1 cycle):
  - LOAD/STORE/ALUI: alu_src_imm=1, alu_op=00.
  - RTYPE: alu_src_imm=0, alu_op=10.
  - BEQ: alu_src_imm=0, alu_op=01. If alu_zero=1, pc_en=1 and pc_src_br=1.
  - Next state: LOAD/STORE go to MEM; ALUI/RTYPE go to WB; BEQ goes to FETCH.
- MEM:
  - dmem_req=1, dmem_we=(STORE); alu_src_imm held at 1.
  - On dmem_ack: LOAD goes to WB, STORE goes to FETCH.
- WB (1 cycle):
  - reg_we=1 for exactly one cycle; wb_sel_mem=(LOAD).
  - Next state: FETCH.
- HALTED: halted=1, all strobes/requests 0; state held until reset.
- FAULT:
  - fault=1, fault_code held, all strobes/requests 0.
  - Held until reset; no further fetches.
- Wait counter:
  - Cleared on every state entry.
  - Increments each cycle in FETCH or MEM while the request is high and ack=0.
  - When the count reaches TIMEOUT with ack still 0: FAULT with code 10 (FETCH) or 11 (MEM); the request drops the next cycle.
  - An ack in the same cycle the count reaches TIMEOUT wins: normal transition, no fault.
- Requests are level-held until ack. Ack outside the matching request state is ignored.
- Reset mid-MEM or mid-FETCH: requests drop immediately (async); the partially executed instruction is discarded; no reg_we.
- Throughput: ALUI/RTYPE take 4 cycles, BEQ 3, STORE 4, LOAD 5, counted with zero-wait ack. Each wait cycle adds 1.

Test Plan:
- ALUI 0x1xxx, imem_ack immediate → FETCH, DECODE, EXEC, WB over cycles 1-4; alu_src_imm=1 in EXEC; reg_we=1 only in cycle 4; next imem_req in cycle 5.
- LOAD 0x0xxx with dmem_ack after 2 wait cycles → dmem_req high 3 cycles, dmem_we=0; WB has wb_sel_mem=1, reg_we=1; 7 cycles total.
- BEQ 0x2xxx with alu_zero=1, then again with alu_zero=0 → first: EXEC pc_en=1, pc_src_br=1. Second: no pc_en in EXEC. Both return to FETCH after 3 cycles.
- STORE 0x8xxx then opcode 0x5 → STORE: dmem_we=1 in MEM, no reg_we. Opcode 0x5: fault=1, fault_code=01 after DECODE; no further imem_req.
- dmem_ack never asserted, TIMEOUT=15 → fault=1, fault_code=11 after 15 wait cycles, dmem_req=0 afterwards. Repeat with ack on cycle 15 → no fault.
- rst_n pulsed low during MEM of a STORE; separately, HALT 0xFxxx → reset: dmem_req drops asynchronously, restart at FETCH with all outputs 0. HALT: halted=1 held, no requests.

Source files
------------

// File: rtl/cpu_ctrl_fsm_if.sv
// cpu_ctrl_fsm_if: bus bundle between the control sequencer and the rest
// of the core (instruction memory, data memory, datapath).
//   master : the sequencer (drives requests, strobes and selects)
//   slave  : memories/datapath (drive ins, acks and the ALU zero flag)
interface cpu_ctrl_fsm_if;
    // memory / datapath -> sequencer
    logic [15:0] ins;
    logic        imem_ack;
    logic        dmem_ack;
    logic        alu_zero;
    // sequencer -> memory / datapath
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_load;
    logic        pc_en;
    logic        pc_src_br;
    logic        alu_src_imm;
    logic [1:0]  alu_op;
    logic        reg_we;
    logic        wb_sel_mem;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;

    modport master (
        input  ins, imem_ack, dmem_ack, alu_zero,
        output imem_req, dmem_req, dmem_we, ir_load, pc_en, pc_src_br,
               alu_src_imm, alu_op, reg_we, wb_sel_mem, halted, fault,
               fault_code
    );

    modport slave (
        output ins, imem_ack, dmem_ack, alu_zero,
        input  imem_req, dmem_req, dmem_we, ir_load, pc_en, pc_src_br,
               alu_src_imm, alu_op, reg_we, wb_sel_mem, halted, fault,
               fault_code
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control sequencer for the 16-bit core.
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with HALTED and FAULT
// as terminal states left only through reset. A wait counter watches the
// imem/dmem handshakes and raises a sticky bus-timeout fault.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : cpu_ctrl_fsm_if.master (fetch/data handshakes, datapath
//            selects, status halted/fault/fault_code)
// Parameters:
//   TIMEOUT : wait cycles allowed on an unacknowledged request (1..255)
//   CNT_W   : wait counter width, 2**CNT_W > TIMEOUT
module cpu_ctrl_fsm #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_ctrl_fsm_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_FAULT
    } state_e;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_ALUI  = 4'b0001;
    localparam logic [3:0] OP_BEQ   = 4'b0010;
    localparam logic [3:0] OP_RTYPE = 4'b0011;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // The wait cycle in which the counter would reach TIMEOUT is the last
    // one tolerated; an ack arriving in that same cycle still wins.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    logic [3:0]       opcode_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       fault_code_q;

    logic legal;
    always_comb begin
        case (opcode_q)
            OP_LOAD, OP_ALUI, OP_BEQ, OP_RTYPE, OP_STORE, OP_HALT: legal = 1'b1;
            default:                                               legal = 1'b0;
        endcase
    end

    // Sequencer state, latched opcode, wait counter and fault code.
    // The counter is cleared on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            opcode_q     <= 4'b0000;
            cnt_q        <= '0;
            fault_code_q <= 2'b00;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        opcode_q <= bus.ins[15:12];
                        state_q  <= S_DECODE;
                        cnt_q    <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q      <= S_FAULT;
                        fault_code_q <= 2'b10;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    cnt_q <= '0;
                    if (!legal) begin
                        state_q      <= S_FAULT;
                        fault_code_q <= 2'b01;
                    end else if (opcode_q == OP_HALT) begin
                        state_q <= S_HALTED;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    cnt_q <= '0;
                    case (opcode_q)
                        OP_LOAD, OP_STORE: state_q <= S_MEM;
                        OP_ALUI, OP_RTYPE: state_q <= S_WB;
                        default:           state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        state_q <= (opcode_q == OP_LOAD) ? S_WB : S_FETCH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q      <= S_FAULT;
                        fault_code_q <= 2'b11;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WB: begin
                    cnt_q   <= '0;
                    state_q <= S_FETCH;
                end
                default: begin
                    // HALTED / FAULT: held until reset
                    cnt_q <= '0;
                end
            endcase
        end
    end

    // Output decode from {state, opcode}. The FETCH request and strobes are
    // gated by rst_n because reset parks the state in FETCH, and all
    // outputs must read 0 while reset is asserted.
    always_comb begin
        bus.imem_req    = 1'b0;
        bus.dmem_req    = 1'b0;
        bus.dmem_we     = 1'b0;
        bus.ir_load     = 1'b0;
        bus.pc_en       = 1'b0;
        bus.pc_src_br   = 1'b0;
        bus.alu_src_imm = 1'b0;
        bus.alu_op      = 2'b00;
        bus.reg_we      = 1'b0;
        bus.wb_sel_mem  = 1'b0;
        bus.halted      = 1'b0;
        bus.fault       = 1'b0;
        bus.fault_code  = 2'b00;
        case (state_q)
            S_FETCH: begin
                bus.imem_req = rst_n;
                if (rst_n && bus.imem_ack) begin
                    bus.ir_load = 1'b1;
                    bus.pc_en   = 1'b1;
                end
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_RTYPE: bus.alu_op = 2'b10;
                    OP_BEQ: begin
                        bus.alu_op = 2'b01;
                        if (bus.alu_zero) begin
                            bus.pc_en     = 1'b1;
                            bus.pc_src_br = 1'b1;
                        end
                    end
                    default: bus.alu_src_imm = 1'b1;  // LOAD/STORE/ALUI
                endcase
            end
            S_MEM: begin
                bus.dmem_req    = 1'b1;
                bus.dmem_we     = (opcode_q == OP_STORE);
                bus.alu_src_imm = 1'b1;  // keep the address stable
            end
            S_WB: begin
                bus.reg_we     = 1'b1;
                bus.wb_sel_mem = (opcode_q == OP_LOAD);
            end
            S_HALTED: bus.halted = 1'b1;
            S_FAULT: begin
                bus.fault      = 1'b1;
                bus.fault_code = fault_code_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed scoreboard bench for cpu_ctrl_fsm.
// The stimulus process drives inputs just after each rising edge and pushes
// the hand-computed output vector for that cycle; the monitor samples on the
// falling edge and compares against the oldest queued expectation.
// Vector layout: {imem_req, dmem_req, dmem_we, ir_load, pc_en, pc_src_br,
//                 alu_src_imm, alu_op[1:0], reg_we, wb_sel_mem, halted,
//                 fault, fault_code[1:0]}
module tb_cpu_ctrl_fsm;

    localparam logic [14:0] IREQ   = 15'h4000;
    localparam logic [14:0] DREQ   = 15'h2000;
    localparam logic [14:0] DWE    = 15'h1000;
    localparam logic [14:0] IRL    = 15'h0800;
    localparam logic [14:0] PCE    = 15'h0400;
    localparam logic [14:0] PCBR   = 15'h0200;
    localparam logic [14:0] IMM    = 15'h0100;
    localparam logic [14:0] OP_R   = 15'h0080;
    localparam logic [14:0] OP_SUB = 15'h0040;
    localparam logic [14:0] RWE    = 15'h0020;
    localparam logic [14:0] WBM    = 15'h0010;
    localparam logic [14:0] HLT    = 15'h0008;
    localparam logic [14:0] FLT    = 15'h0004;
    localparam logic [14:0] C_ILL  = 15'h0001;
    localparam logic [14:0] C_IMEM = 15'h0002;
    localparam logic [14:0] C_DMEM = 15'h0003;
    localparam logic [14:0] FETCHV = IREQ | IRL | PCE;

    typedef struct {
        logic [14:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_v = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cpu_ctrl_fsm_if bus();

    cpu_ctrl_fsm #(.TIMEOUT(15), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    logic [14:0] act;
    assign act = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_load,
                  bus.pc_en, bus.pc_src_br, bus.alu_src_imm, bus.alu_op,
                  bus.reg_we, bus.wb_sel_mem, bus.halted, bus.fault,
                  bus.fault_code};

    // One cycle of stimulus plus the outputs expected during that cycle.
    task automatic cyc(input logic [15:0] ins, input logic iack,
                       input logic dack, input logic zero,
                       input logic [14:0] exp, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rst_v;
        bus.ins      = ins;
        bus.imem_ack = iack;
        bus.dmem_ack = dack;
        bus.alu_zero = zero;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: the DUT presents a full output vector every cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_total++;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s: got %h expected %h (t=%0t)",
                          e.name, act, e.exp, $time);
        end
    end

    initial begin
        bus.ins = 16'h0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        bus.alu_zero = 1'b0;

        // reset: everything low, including imem_req
        rst_v = 1'b0;
        cyc(16'h0, 0, 0, 0, 15'h0, "reset0");
        cyc(16'h0, 1, 1, 1, 15'h0, "reset1");
        rst_v = 1'b1;

        // ALUI: 4 cycles, reg_we only in WB
        cyc(16'h1234, 1, 0, 0, FETCHV, "alui_fetch");
        cyc(16'h0,    0, 0, 0, 15'h0,  "alui_decode");
        cyc(16'h0,    0, 1, 0, IMM,    "alui_exec");
        cyc(16'h0,    0, 0, 0, RWE,    "alui_wb");

        // LOAD with 2 wait cycles: 7 cycles total
        cyc(16'h0abc, 1, 0, 0, FETCHV,     "load_fetch");
        cyc(16'h0,    0, 0, 0, 15'h0,      "load_decode");
        cyc(16'h0,    0, 0, 0, IMM,        "load_exec");
        cyc(16'h0,    0, 0, 0, DREQ | IMM, "load_wait1");
        cyc(16'h0,    0, 0, 0, DREQ | IMM, "load_wait2");
        cyc(16'h0,    0, 1, 0, DREQ | IMM, "load_ack");
        cyc(16'h0,    0, 0, 0, RWE | WBM,  "load_wb");

        // BEQ taken, then not taken
        cyc(16'h2000, 1, 0, 0, FETCHV,              "beq_t_fetch");
        cyc(16'h0,    0, 0, 1, 15'h0,               "beq_t_decode");
        cyc(16'h0,    0, 0, 1, OP_SUB | PCE | PCBR, "beq_t_exec");
        cyc(16'h2fff, 1, 0, 1, FETCHV,              "beq_n_fetch");
        cyc(16'h0,    0, 0, 0, 15'h0,               "beq_n_decode");
        cyc(16'h0,    0, 0, 0, OP_SUB,              "beq_n_exec");

        // RTYPE: register operand, funct-decoded op
        cyc(16'h3123, 1, 0, 0, FETCHV, "rtype_fetch");
        cyc(16'h0,    0, 0, 0, 15'h0,  "rtype_decode");
        cyc(16'h0,    0, 0, 0, OP_R,   "rtype_exec");
        cyc(16'h0,    0, 0, 0, RWE,    "rtype_wb");

        // STORE, zero-wait, no reg_we
        cyc(16'h8001, 1, 0, 0, FETCHV,           "st_fetch");
        cyc(16'h0,    0, 0, 0, 15'h0,            "st_decode");
        cyc(16'h0,    0, 0, 0, IMM,              "st_exec");
        cyc(16'h0,    0, 1, 0, DREQ | DWE | IMM, "st_mem");

        // STORE with ack in the 15th wait cycle: ack wins, no fault
        cyc(16'h8002, 1, 0, 0, FETCHV, "st15_fetch");
        cyc(16'h0,    0, 0, 0, 15'h0,  "st15_decode");
        cyc(16'h0,    0, 0, 0, IMM,    "st15_exec");
        for (int i = 1; i < 15; i++)
            cyc(16'h0, 0, 0, 0, DREQ | DWE | IMM, "st15_wait");
        cyc(16'h0, 0, 1, 0, DREQ | DWE | IMM, "st15_ack");
        cyc(16'h0, 0, 0, 0, IREQ,             "st15_refetch");
        cyc(16'h0, 0, 0, 0, IREQ,             "st15_refetch2");

        // LOAD never acked: fault 11 after 15 wait cycles
        cyc(16'h0123, 1, 0, 0, FETCHV, "dto_fetch");
        cyc(16'h0,    0, 0, 0, 15'h0,  "dto_decode");
        cyc(16'h0,    0, 0, 0, IMM,    "dto_exec");
        for (int i = 0; i < 15; i++)
            cyc(16'h0, 0, 0, 0, DREQ | IMM, "dto_wait");
        cyc(16'h0, 1, 1, 0, FLT | C_DMEM, "dto_fault0");
        cyc(16'h0, 1, 1, 0, FLT | C_DMEM, "dto_fault1");
        cyc(16'h0, 0, 0, 0, FLT | C_DMEM, "dto_fault2");

        // reset clears the fault; fetch never acked: fault 10
        rst_v = 1'b0;
        cyc(16'h0, 0, 0, 0, 15'h0, "rst_after_dto");
        rst_v = 1'b1;
        for (int i = 0; i < 15; i++)
            cyc(16'h0, 0, 0, 0, IREQ, "ito_wait");
        cyc(16'h0, 1, 0, 0, FLT | C_IMEM, "ito_fault0");
        cyc(16'h0, 1, 0, 0, FLT | C_IMEM, "ito_fault1");

        // illegal opcode 0x5: fault 01 after DECODE, no further fetch
        rst_v = 1'b0;
        cyc(16'h0, 0, 0, 0, 15'h0, "rst_after_ito");
        rst_v = 1'b1;
        cyc(16'h5000, 1, 0, 0, FETCHV,      "ill_fetch");
        cyc(16'h0,    1, 0, 0, 15'h0,       "ill_decode");
        cyc(16'h1000, 1, 0, 0, FLT | C_ILL, "ill_fault0");
        cyc(16'h1000, 1, 1, 0, FLT | C_ILL, "ill_fault1");
        cyc(16'h0,    0, 0, 0, FLT | C_ILL, "ill_fault2");

        // reset mid-MEM of a STORE: dmem_req drops before the next edge
        rst_v = 1'b0;
        cyc(16'h0, 0, 0, 0, 15'h0, "rst_after_ill");
        rst_v = 1'b1;
        cyc(16'h8003, 1, 0, 0, FETCHV,           "rm_fetch");
        cyc(16'h0,    0, 0, 0, 15'h0,            "rm_decode");
        cyc(16'h0,    0, 0, 0, IMM,              "rm_exec");
        cyc(16'h0,    0, 0, 0, DREQ | DWE | IMM, "rm_mem");
        rst_v = 1'b0;
        cyc(16'h0, 0, 1, 0, 15'h0, "rm_async_drop");
        rst_v = 1'b1;
        cyc(16'h0, 0, 1, 0, IREQ,  "rm_restart");

        // HALT: halted held, requests ignored
        cyc(16'hf000, 1, 0, 0, FETCHV, "halt_fetch");
        cyc(16'h0,    0, 0, 0, 15'h0,  "halt_decode");
        cyc(16'h1000, 1, 1, 0, HLT,    "halt_0");
        cyc(16'h1000, 1, 1, 1, HLT,    "halt_1");
        cyc(16'h0,    0, 0, 0, HLT,    "halt_2");

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
